int_cmd_in_writer: RTL and testbench
====================================

INT_CMD_IN_WRITER -- requirements
Module: int_cmd_in_writer

Interface
REQ-001 SHALL have parameters MAX_ACCS (default 16; number of accelerator subqueues), ACC_BITS (default 4; accelerator id width), SUBQUEUE_BITS (default 6; log2 of words per subqueue).
REQ-002 SHALL use package constants ENTRY_VALID_OFFSET=63, CMD_TYPE_L=0 (4 bits), NUM_ARGS_OFFSET=8 (4 bits), EXEC_TASK_CODE=4'h1.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 inStream_TDATA/TVALID/TREADY/TLAST  in/in/out/in  64/1/1/1  task-creation commands from accelerators.
REQ-006 inStream_TDEST  in  4  target accelerator (subqueue) id; low ACC_BITS used.
REQ-007 intCmdInQueue_addr/en/we/din  out  10/1/1/64  write port of the internal command-in queue; addr = {acc_id, slot}, upper unused bits 0.
REQ-008 intCmdInQueue_dout  in  64  read data, valid 1 cycle after en.
REQ-009 sched_queue_nempty_address/sched_queue_nempty_write  out  4/1  one-cycle notification that a subqueue holds a new command.
REQ-010 protocol_err  out  1  sticky; TLAST disagreed with header-derived length.

Function
REQ-011 Command length L = 3+2*N if header type == EXEC_TASK_CODE, else 4+2*N; N = header[11:8], so 3 <= L <= 34.
REQ-012 Per-subqueue write pointer wr_idx[acc] (SUBQUEUE_BITS); all slot arithmetic modulo 2^SUBQUEUE_BITS (wrap 63 -> 0).
REQ-013 States: IDLE, CHK_FIRST, CHK_LAST, EVAL, WR_BODY, WR_HDR, NOTIFY.
REQ-014 IDLE: TREADY=0; when TVALID, latch header=TDATA, acc=TDEST, compute L, go CHK_FIRST.
REQ-015 CHK_FIRST: en=1, we=0, addr={acc, wr_idx[acc]}; go CHK_LAST.
REQ-016 CHK_LAST: en=1, we=0, addr={acc, wr_idx[acc]+L-1}; latch first-slot valid bit from dout; go EVAL.
REQ-017 EVAL: if first and last slot valid bits both 0, go WR_BODY; else go CHK_FIRST (poll until Command_In frees space); no stream word consumed while polling.
REQ-018 WR_BODY: first cycle TREADY=1 consumes the header beat without writing; then each accepted beat k (1..L-1) writes TDATA to slot wr_idx+k with din[63] forced to 1; TREADY=1 throughout.
REQ-019 After beat L-1 accepted, TREADY drops the next cycle, go WR_HDR.
REQ-020 WR_HDR: write latched header with bit 63 = 1 at slot wr_idx; header is always written last so the consumer never sees a partial command; go NOTIFY.
REQ-021 NOTIFY: sched_queue_nempty_write=1 for exactly one cycle, address=acc; wr_idx[acc] += L; go IDLE.
REQ-022 TLAST on beat j: if (j==L-1) != TLAST, set protocol_err; block still consumes exactly L beats (length from header is authoritative).
REQ-023 Throughput: one beat per cycle in WR_BODY when TVALID=1; TVALID low stalls without writes.
REQ-024 Commands to different subqueues are independent; back-to-back commands to the same subqueue land contiguously.
REQ-025 Outside CHK_FIRST/CHK_LAST/WR_BODY/WR_HDR: intCmdInQueue_en=0, we=0.

Reset
REQ-026 While rstn=0 at a clock edge: state=IDLE, all wr_idx=0, protocol_err=0, TREADY=0, sched_queue_nempty_write=0, en=0, we=0.
REQ-027 Reset mid-command abandons it: no header write, no notify; already-written body slots remain with valid set (bench re-initialises the queue RAM).

Verification
REQ-028 Exec task, TDEST=3, N=2, empty RAM -> L=7; body slots 193..198 written, then header at 192 with bit63=1, one nempty pulse addr=3, wr_idx[3]=7.
REQ-029 Periodic task, N=0, TDEST=0, wr_idx[0]=62 -> L=4; writes slots 63,0,1 then header at 62; wr_idx[0]=2.
REQ-030 Last target slot valid=1 -> TREADY stays 0 and repeated reads occur; clear that slot -> command completes within 3+L+2 cycles.
REQ-031 TLAST asserted on beat 3 of an L=5 command -> protocol_err=1, all 5 beats consumed, notify still issued.
REQ-032 TVALID toggled every other cycle during body -> writes only on accepted beats, correct slots, single notify.
REQ-033 rstn low during WR_BODY -> no header write, no notify, wr_idx all 0, next command starts at slot 0.

Source files
------------

// File: rtl/int_cmd_in_writer.sv
// Internal command-in writer: copies task-creation commands from the
// accelerator stream into per-accelerator circular subqueues, writing the
// body first and the header last so a consumer never sees a partial command.

package int_cmd_in_writer_pkg;
    localparam int         ENTRY_VALID_OFFSET = 63;
    localparam int         CMD_TYPE_L         = 0;
    localparam int         CMD_TYPE_W         = 4;
    localparam int         NUM_ARGS_OFFSET    = 8;
    localparam int         NUM_ARGS_W         = 4;
    localparam logic [3:0] EXEC_TASK_CODE     = 4'h1;
endpackage

// state     | meaning
// IDLE      | wait for a header on the stream (peeked, not consumed)
// CHK_FIRST | read first target slot of the subqueue
// CHK_LAST  | read last target slot, capture first slot valid bit
// EVAL      | both slots free -> write, otherwise poll again
// WR_BODY   | consume header beat, then write body beats to slots 1..L-1
// WR_HDR    | write the latched header to slot 0 with valid set
// NOTIFY    | one-cycle non-empty pulse, advance the write pointer
module int_cmd_in_writer
    import int_cmd_in_writer_pkg::*;
#(
    parameter int MAX_ACCS      = 16,
    parameter int ACC_BITS      = 4,
    parameter int SUBQUEUE_BITS = 6
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] inStream_TDATA,
    input  logic        inStream_TVALID,
    output logic        inStream_TREADY,
    input  logic        inStream_TLAST,
    input  logic [3:0]  inStream_TDEST,
    output logic [9:0]  intCmdInQueue_addr,
    output logic        intCmdInQueue_en,
    output logic        intCmdInQueue_we,
    output logic [63:0] intCmdInQueue_din,
    input  logic [63:0] intCmdInQueue_dout,
    output logic [3:0]  sched_queue_nempty_address,
    output logic        sched_queue_nempty_write,
    output logic        protocol_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK_FIRST,
        S_CHK_LAST,
        S_EVAL,
        S_WR_BODY,
        S_WR_HDR,
        S_NOTIFY
    } state_e;

    state_e                   state_q, state_d;
    logic [63:0]              hdr_q;
    logic [ACC_BITS-1:0]      acc_q;
    logic [5:0]               len_q;
    logic [5:0]               beat_q;
    logic                     first_valid_q;
    logic                     protocol_err_q;
    logic [SUBQUEUE_BITS-1:0] wr_idx_q [MAX_ACCS];

    logic [CMD_TYPE_W-1:0]    hdr_type;
    logic [NUM_ARGS_W-1:0]    hdr_nargs;
    logic [5:0]               len_in;
    logic [SUBQUEUE_BITS-1:0] slot_base;
    logic [SUBQUEUE_BITS-1:0] slot_last;
    logic [SUBQUEUE_BITS-1:0] slot_body;
    logic [SUBQUEUE_BITS-1:0] slot_sel;
    logic                     beat_last;
    logic                     accept;
    logic                     unused_dout;

    // Only the valid bit of read data matters for the free-space check.
    assign unused_dout = ^intCmdInQueue_dout;

    // Header decode and slot arithmetic (all modulo the subqueue size).
    always_comb begin
        hdr_type  = inStream_TDATA[CMD_TYPE_L +: CMD_TYPE_W];
        hdr_nargs = inStream_TDATA[NUM_ARGS_OFFSET +: NUM_ARGS_W];
        if (hdr_type == EXEC_TASK_CODE) begin
            len_in = 6'd3 + {1'b0, hdr_nargs, 1'b0};
        end else begin
            len_in = 6'd4 + {1'b0, hdr_nargs, 1'b0};
        end
        slot_base = wr_idx_q[acc_q];
        slot_last = slot_base + SUBQUEUE_BITS'(len_q - 6'd1);
        slot_body = slot_base + SUBQUEUE_BITS'(beat_q);
        beat_last = (beat_q == (len_q - 6'd1));
        accept    = (state_q == S_WR_BODY) && inStream_TVALID;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (inStream_TVALID) state_d = S_CHK_FIRST;
            S_CHK_FIRST: state_d = S_CHK_LAST;
            S_CHK_LAST:  state_d = S_EVAL;
            S_EVAL: begin
                if (!first_valid_q && !intCmdInQueue_dout[ENTRY_VALID_OFFSET]) begin
                    state_d = S_WR_BODY;
                end else begin
                    state_d = S_CHK_FIRST;
                end
            end
            S_WR_BODY:   if (accept && beat_last) state_d = S_WR_HDR;
            S_WR_HDR:    state_d = S_NOTIFY;
            S_NOTIFY:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Command context, beat counter, sticky error and per-subqueue pointers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hdr_q          <= '0;
            acc_q          <= '0;
            len_q          <= '0;
            beat_q         <= '0;
            first_valid_q  <= 1'b0;
            protocol_err_q <= 1'b0;
            for (int i = 0; i < MAX_ACCS; i++) begin
                wr_idx_q[i] <= '0;
            end
        end else begin
            if (state_q == S_IDLE && inStream_TVALID) begin
                hdr_q <= inStream_TDATA;
                acc_q <= inStream_TDEST[ACC_BITS-1:0];
                len_q <= len_in;
            end
            if (state_q == S_CHK_LAST) begin
                first_valid_q <= intCmdInQueue_dout[ENTRY_VALID_OFFSET];
            end
            if (state_q == S_EVAL) begin
                beat_q <= '0;
            end
            if (accept) begin
                beat_q <= beat_q + 6'd1;
                // Header length is authoritative; TLAST is only cross-checked.
                if (beat_last != inStream_TLAST) begin
                    protocol_err_q <= 1'b1;
                end
            end
            if (state_q == S_NOTIFY) begin
                wr_idx_q[acc_q] <= wr_idx_q[acc_q] + SUBQUEUE_BITS'(len_q);
            end
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        inStream_TREADY            = 1'b0;
        intCmdInQueue_en           = 1'b0;
        intCmdInQueue_we           = 1'b0;
        intCmdInQueue_din          = '0;
        slot_sel                   = slot_base;
        sched_queue_nempty_write   = 1'b0;
        sched_queue_nempty_address = 4'(acc_q);
        case (state_q)
            S_CHK_FIRST: begin
                intCmdInQueue_en = 1'b1;
                slot_sel         = slot_base;
            end
            S_CHK_LAST: begin
                intCmdInQueue_en = 1'b1;
                slot_sel         = slot_last;
            end
            S_WR_BODY: begin
                inStream_TREADY = 1'b1;
                // Beat 0 is the header already latched; it is written last.
                if (accept && beat_q != 6'd0) begin
                    intCmdInQueue_en                      = 1'b1;
                    intCmdInQueue_we                      = 1'b1;
                    slot_sel                              = slot_body;
                    intCmdInQueue_din                     = inStream_TDATA;
                    intCmdInQueue_din[ENTRY_VALID_OFFSET] = 1'b1;
                end
            end
            S_WR_HDR: begin
                intCmdInQueue_en                      = 1'b1;
                intCmdInQueue_we                      = 1'b1;
                slot_sel                              = slot_base;
                intCmdInQueue_din                     = hdr_q;
                intCmdInQueue_din[ENTRY_VALID_OFFSET] = 1'b1;
            end
            S_NOTIFY: begin
                sched_queue_nempty_write = 1'b1;
            end
            default: ;
        endcase
        intCmdInQueue_addr = 10'({acc_q, slot_sel});
    end

    assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_int_cmd_in_writer.sv
// Directed bench for int_cmd_in_writer with a behavioural queue RAM model.
module tb_int_cmd_in_writer;

    localparam logic [63:0] VBIT = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [63:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        tlast = 1'b0;
    logic [3:0]  tdest = '0;
    logic [9:0]  q_addr;
    logic        q_en, q_we;
    logic [63:0] q_din;
    logic [63:0] q_dout;
    logic [3:0]  nq_addr;
    logic        nq_wr;
    logic        perr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    int_cmd_in_writer dut (
        .clk                        (clk),
        .rstn                       (rstn),
        .inStream_TDATA             (tdata),
        .inStream_TVALID            (tvalid),
        .inStream_TREADY            (tready),
        .inStream_TLAST             (tlast),
        .inStream_TDEST             (tdest),
        .intCmdInQueue_addr         (q_addr),
        .intCmdInQueue_en           (q_en),
        .intCmdInQueue_we           (q_we),
        .intCmdInQueue_din          (q_din),
        .intCmdInQueue_dout         (q_dout),
        .sched_queue_nempty_address (nq_addr),
        .sched_queue_nempty_write   (nq_wr),
        .protocol_err               (perr)
    );

    // Queue RAM model plus monitors.
    logic [63:0] mem [1024];
    logic        clr_all = 1'b0;
    logic        poke_en = 1'b0;
    logic [9:0]  poke_addr = '0;
    logic        poke_val = 1'b0;
    int          wr_addr_log[$];
    logic [63:0] wr_data_log[$];
    int          notify_cnt = 0;
    int          notify_last = -1;
    int          notify_cycle = 0;
    int          poke_cycle = 0;
    int          read_cnt = 0;
    int          tready_hi_cnt = 0;
    int          cyc_cnt = 0;

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (clr_all) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (poke_en) begin
            mem[poke_addr][63] <= poke_val;
            poke_cycle <= cyc_cnt;
        end
        if (q_en) begin
            if (q_we) begin
                mem[q_addr] <= q_din;
                wr_addr_log.push_back(int'(q_addr));
                wr_data_log.push_back(q_din);
            end else begin
                q_dout   <= mem[q_addr];
                read_cnt <= read_cnt + 1;
            end
        end
        if (nq_wr) begin
            notify_cnt   <= notify_cnt + 1;
            notify_last  <= int'(nq_addr);
            notify_cycle <= cyc_cnt;
        end
        if (tready) tready_hi_cnt <= tready_hi_cnt + 1;
    end

    function automatic logic [63:0] bw(input int tag, input int k);
        return 64'h4000_0000_0000_0000 | (64'(tag) << 16) | 64'(k);
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mem();
        @(negedge clk);
        clr_all = 1'b1;
        @(negedge clk);
        clr_all = 1'b0;
    endtask

    task automatic poke(input int addr, input logic val);
        @(negedge clk);
        poke_addr = 10'(addr);
        poke_val  = val;
        poke_en   = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Streams one command; a beat counts as accepted when TVALID and TREADY
    // are both high across a rising edge. Stops early at beat abort_at.
    task automatic send_cmd(input int acc, input logic [63:0] hdr, input int tag,
                            input int len, input int tlast_pos, input bit gap,
                            input int abort_at, output int beats);
        int j;
        int cyc;
        bit acc_now;
        j   = 0;
        cyc = 0;
        @(negedge clk);
        tdest  = 4'(acc);
        tdata  = hdr;
        tvalid = 1'b1;
        tlast  = (tlast_pos == 0);
        while (j < len && j != abort_at && cyc < 200) begin
            acc_now = tvalid && tready;
            @(negedge clk);
            cyc++;
            if (acc_now) j++;
            if (j < len) begin
                tdata = (j == 0) ? hdr : bw(tag, j);
                tlast = (j == tlast_pos);
                if (gap) tvalid = ~tvalid;
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        beats  = j;
        if (cyc >= 200) begin
            checks++; errors++;
            $display("FAIL stream_timeout: beats accepted=%0d required=%0d", j, len);
        end
    endtask

    task automatic test_reset();
        rstn    = 1'b0;
        clr_all = 1'b1;
        wait_cycles(3);
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", tready); end
        checks++; if (q_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", q_en); end
        checks++; if (q_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", q_we); end
        checks++; if (nq_wr !== 1'b0) begin errors++; $display("FAIL reset_notify: got %b want 0", nq_wr); end
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", perr); end
        clr_all = 1'b0;
        rstn    = 1'b1;
        wait_cycles(2);
    endtask

    // acc 3, exec, N=2 -> L=7: body 193..198, header 192.
    task automatic test_exec();
        int n0, nn, beats;
        int exp_a[$];
        logic [63:0] exp_d[$];
        n0 = wr_addr_log.size(); nn = notify_cnt;
        send_cmd(3, 64'h0000_00AB_0000_0201, 1, 7, 6, 1'b0, -1, beats);
        wait_cycles(3);
        for (int k = 1; k < 7; k++) begin exp_a.push_back(192 + k); exp_d.push_back(bw(1, k) | VBIT); end
        exp_a.push_back(192); exp_d.push_back(64'h8000_00AB_0000_0201);
        checks++; if (wr_addr_log.size() - n0 !== 7) begin errors++; $display("FAIL exec_wr_count: got %0d want 7", wr_addr_log.size() - n0); end
        for (int i = 0; i < 7 && n0 + i < wr_addr_log.size(); i++) begin
            checks++;
            if (wr_addr_log[n0+i] !== exp_a[i] || wr_data_log[n0+i] !== exp_d[i]) begin
                errors++; $display("FAIL exec_wr%0d: got addr %0d data %h want addr %0d data %h", i, wr_addr_log[n0+i], wr_data_log[n0+i], exp_a[i], exp_d[i]);
            end
        end
        checks++; if (notify_cnt - nn !== 1 || notify_last !== 3) begin errors++; $display("FAIL exec_notify: got count %0d addr %0d want 1 addr 3", notify_cnt - nn, notify_last); end
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL exec_perr: got %b want 0", perr); end
    endtask

    // acc 3 again, periodic N=1 -> L=6 starting at wr_idx 7: body 200..204, header 199.
    task automatic test_back_to_back();
        int n0, nn, beats;
        int exp_a[$];
        logic [63:0] exp_d[$];
        n0 = wr_addr_log.size(); nn = notify_cnt;
        send_cmd(3, 64'h0000_00BC_0000_0102, 2, 6, 5, 1'b0, -1, beats);
        wait_cycles(3);
        for (int k = 1; k < 6; k++) begin exp_a.push_back(199 + k); exp_d.push_back(bw(2, k) | VBIT); end
        exp_a.push_back(199); exp_d.push_back(64'h8000_00BC_0000_0102);
        checks++; if (wr_addr_log.size() - n0 !== 6) begin errors++; $display("FAIL b2b_wr_count: got %0d want 6", wr_addr_log.size() - n0); end
        for (int i = 0; i < 6 && n0 + i < wr_addr_log.size(); i++) begin
            checks++;
            if (wr_addr_log[n0+i] !== exp_a[i] || wr_data_log[n0+i] !== exp_d[i]) begin
                errors++; $display("FAIL b2b_wr%0d: got addr %0d data %h want addr %0d data %h", i, wr_addr_log[n0+i], wr_data_log[n0+i], exp_a[i], exp_d[i]);
            end
        end
        checks++; if (notify_cnt - nn !== 1 || notify_last !== 3) begin errors++; $display("FAIL b2b_notify: got count %0d addr %0d want 1 addr 3", notify_cnt - nn, notify_last); end
    endtask

    // Two L=31 fillers bring wr_idx[0] to 62; then periodic N=0 (L=4) wraps.
    task automatic test_wrap();
        int n0, nn, beats;
        int exp_a[$];
        logic [63:0] exp_d[$];
        nn = notify_cnt;
        send_cmd(0, 64'h0000_0000_0000_0E01, 8, 31, 30, 1'b0, -1, beats);
        wait_cycles(3);
        send_cmd(0, 64'h0000_0000_0000_0E01, 9, 31, 30, 1'b0, -1, beats);
        wait_cycles(3);
        checks++; if (notify_cnt - nn !== 2) begin errors++; $display("FAIL wrap_fill_notify: got %0d want 2", notify_cnt - nn); end
        clear_mem();
        n0 = wr_addr_log.size(); nn = notify_cnt;
        send_cmd(0, 64'h0000_0033_0000_0002, 3, 4, 3, 1'b0, -1, beats);
        wait_cycles(3);
        exp_a = '{63, 0, 1, 62};
        exp_d = '{bw(3, 1) | VBIT, bw(3, 2) | VBIT, bw(3, 3) | VBIT, 64'h8000_0033_0000_0002};
        checks++; if (wr_addr_log.size() - n0 !== 4) begin errors++; $display("FAIL wrap_wr_count: got %0d want 4", wr_addr_log.size() - n0); end
        for (int i = 0; i < 4 && n0 + i < wr_addr_log.size(); i++) begin
            checks++;
            if (wr_addr_log[n0+i] !== exp_a[i] || wr_data_log[n0+i] !== exp_d[i]) begin
                errors++; $display("FAIL wrap_wr%0d: got addr %0d data %h want addr %0d data %h", i, wr_addr_log[n0+i], wr_data_log[n0+i], exp_a[i], exp_d[i]);
            end
        end
        checks++; if (notify_cnt - nn !== 1 || notify_last !== 0) begin errors++; $display("FAIL wrap_notify: got count %0d addr %0d want 1 addr 0", notify_cnt - nn, notify_last); end
    endtask

    // acc 0 now at wr_idx 2; L=4 targets slots 2..5 with slot 5 occupied.
    task automatic test_poll();
        int n0, nn, rc0, th0, beats, elapsed;
        int exp_a[$];
        poke(5, 1'b1);
        n0 = wr_addr_log.size(); nn = notify_cnt; rc0 = read_cnt; th0 = tready_hi_cnt;
        @(negedge clk);
        tdest  = 4'd0;
        tdata  = 64'h0000_0044_0000_0002;
        tlast  = 1'b0;
        tvalid = 1'b1;
        wait_cycles(20);
        checks++; if (tready_hi_cnt !== th0) begin errors++; $display("FAIL poll_tready: got %0d ready cycles want 0", tready_hi_cnt - th0); end
        checks++; if (read_cnt - rc0 < 6) begin errors++; $display("FAIL poll_reads: got %0d reads want at least 6", read_cnt - rc0); end
        checks++; if (wr_addr_log.size() !== n0) begin errors++; $display("FAIL poll_no_write: got %0d writes want 0", wr_addr_log.size() - n0); end
        poke(5, 1'b0);
        send_cmd(0, 64'h0000_0044_0000_0002, 4, 4, 3, 1'b0, -1, beats);
        wait_cycles(3);
        // One cycle of slack covers a poll whose read was already in flight.
        elapsed = notify_cycle - poke_cycle;
        checks++; if (notify_cnt - nn !== 1 || elapsed > 3 + 4 + 3 || elapsed <= 0) begin errors++; $display("FAIL poll_complete: got notify count %0d after %0d cycles want 1 within 10", notify_cnt - nn, elapsed); end
        exp_a = '{3, 4, 5, 2};
        checks++; if (wr_addr_log.size() - n0 !== 4) begin errors++; $display("FAIL poll_wr_count: got %0d want 4", wr_addr_log.size() - n0); end
        for (int i = 0; i < 4 && n0 + i < wr_addr_log.size(); i++) begin
            checks++;
            if (wr_addr_log[n0+i] !== exp_a[i]) begin errors++; $display("FAIL poll_wr%0d: got addr %0d want %0d", i, wr_addr_log[n0+i], exp_a[i]); end
        end
    endtask

    // acc 5, exec N=1 -> L=5, TLAST early on beat 3.
    task automatic test_tlast_err();
        int n0, nn, beats;
        int exp_a[$];
        logic [63:0] exp_d[$];
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL tlast_pre_perr: got %b want 0", perr); end
        n0 = wr_addr_log.size(); nn = notify_cnt;
        send_cmd(5, 64'h0000_00C5_0000_0101, 5, 5, 3, 1'b0, -1, beats);
        wait_cycles(3);
        for (int k = 1; k < 5; k++) begin exp_a.push_back(320 + k); exp_d.push_back(bw(5, k) | VBIT); end
        exp_a.push_back(320); exp_d.push_back(64'h8000_00C5_0000_0101);
        checks++; if (beats !== 5) begin errors++; $display("FAIL tlast_beats: got %0d want 5", beats); end
        checks++; if (perr !== 1'b1) begin errors++; $display("FAIL tlast_perr: got %b want 1", perr); end
        checks++; if (wr_addr_log.size() - n0 !== 5) begin errors++; $display("FAIL tlast_wr_count: got %0d want 5", wr_addr_log.size() - n0); end
        for (int i = 0; i < 5 && n0 + i < wr_addr_log.size(); i++) begin
            checks++;
            if (wr_addr_log[n0+i] !== exp_a[i] || wr_data_log[n0+i] !== exp_d[i]) begin
                errors++; $display("FAIL tlast_wr%0d: got addr %0d data %h want addr %0d data %h", i, wr_addr_log[n0+i], wr_data_log[n0+i], exp_a[i], exp_d[i]);
            end
        end
        checks++; if (notify_cnt - nn !== 1 || notify_last !== 5) begin errors++; $display("FAIL tlast_notify: got count %0d addr %0d want 1 addr 5", notify_cnt - nn, notify_last); end
    endtask

    // acc 7, periodic N=2 -> L=8, TVALID toggling every cycle.
    task automatic test_gap();
        int n0, nn, beats;
        int exp_a[$];
        logic [63:0] exp_d[$];
        n0 = wr_addr_log.size(); nn = notify_cnt;
        send_cmd(7, 64'h0000_00D7_0000_0200, 6, 8, 7, 1'b1, -1, beats);
        wait_cycles(3);
        for (int k = 1; k < 8; k++) begin exp_a.push_back(448 + k); exp_d.push_back(bw(6, k) | VBIT); end
        exp_a.push_back(448); exp_d.push_back(64'h8000_00D7_0000_0200);
        checks++; if (wr_addr_log.size() - n0 !== 8) begin errors++; $display("FAIL gap_wr_count: got %0d want 8", wr_addr_log.size() - n0); end
        for (int i = 0; i < 8 && n0 + i < wr_addr_log.size(); i++) begin
            checks++;
            if (wr_addr_log[n0+i] !== exp_a[i] || wr_data_log[n0+i] !== exp_d[i]) begin
                errors++; $display("FAIL gap_wr%0d: got addr %0d data %h want addr %0d data %h", i, wr_addr_log[n0+i], wr_data_log[n0+i], exp_a[i], exp_d[i]);
            end
        end
        checks++; if (notify_cnt - nn !== 1 || notify_last !== 7) begin errors++; $display("FAIL gap_notify: got count %0d addr %0d want 1 addr 7", notify_cnt - nn, notify_last); end
        checks++; if (perr !== 1'b1) begin errors++; $display("FAIL gap_perr_sticky: got %b want 1", perr); end
    endtask

    // acc 2, exec N=3 -> L=9, reset after 4 beats; then acc 3 restarts at slot 0.
    task automatic test_reset_mid();
        int n0, nn, beats, hdr_hits;
        int exp_a[$];
        logic [63:0] exp_d[$];
        n0 = wr_addr_log.size(); nn = notify_cnt;
        send_cmd(2, 64'h0000_00E2_0000_0301, 6, 9, 8, 1'b0, 4, beats);
        rstn = 1'b0;
        wait_cycles(2);
        checks++; if (tready !== 1'b0 || q_en !== 1'b0 || nq_wr !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got ready %b en %b notify %b want 0 0 0", tready, q_en, nq_wr); end
        rstn = 1'b1;
        wait_cycles(3);
        hdr_hits = 0;
        for (int i = n0; i < wr_addr_log.size(); i++) if (wr_addr_log[i] == 128) hdr_hits++;
        checks++; if (wr_addr_log.size() - n0 !== 3 || hdr_hits !== 0) begin errors++; $display("FAIL midrst_writes: got %0d writes %0d header writes want 3 and 0", wr_addr_log.size() - n0, hdr_hits); end
        checks++; if (notify_cnt !== nn) begin errors++; $display("FAIL midrst_notify: got %0d pulses want 0", notify_cnt - nn); end
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL midrst_perr: got %b want 0", perr); end
        clear_mem();
        n0 = wr_addr_log.size(); nn = notify_cnt;
        send_cmd(3, 64'h0000_00F3_0000_0002, 7, 4, 3, 1'b0, -1, beats);
        wait_cycles(3);
        exp_a = '{193, 194, 195, 192};
        exp_d = '{bw(7, 1) | VBIT, bw(7, 2) | VBIT, bw(7, 3) | VBIT, 64'h8000_00F3_0000_0002};
        checks++; if (wr_addr_log.size() - n0 !== 4) begin errors++; $display("FAIL midrst_next_count: got %0d want 4", wr_addr_log.size() - n0); end
        for (int i = 0; i < 4 && n0 + i < wr_addr_log.size(); i++) begin
            checks++;
            if (wr_addr_log[n0+i] !== exp_a[i] || wr_data_log[n0+i] !== exp_d[i]) begin
                errors++; $display("FAIL midrst_next_wr%0d: got addr %0d data %h want addr %0d data %h", i, wr_addr_log[n0+i], wr_data_log[n0+i], exp_a[i], exp_d[i]);
            end
        end
        checks++; if (notify_cnt - nn !== 1 || notify_last !== 3) begin errors++; $display("FAIL midrst_next_notify: got count %0d addr %0d want 1 addr 3", notify_cnt - nn, notify_last); end
    endtask

    initial begin
        test_reset();
        test_exec();
        test_back_to_back();
        test_wrap();
        test_poll();
        test_tlast_err();
        test_gap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete within bound");
        $fatal(1, "timeout");
    end

endmodule
